// File: rtl/swq_pkg.sv
// swq_pkg: shared constants and types for the switch ingress queue stage.
// Register map: 0 = status, 1..3 = queue push, 4..7 = drop counters.
package swq_pkg;

    localparam int MAX_PORTS  = 3;
    localparam int DROP_CNT_W = 8;

    localparam logic [2:0] ADDR_STATUS    = 3'd0;
    localparam logic [2:0] ADDR_Q_BASE    = 3'd1;
    localparam logic [2:0] ADDR_DROP_BASE = 3'd4;

    // Index of a queue / egress source port.
    typedef logic [1:0] port_idx_t;

    // Round-robin helper: reduce an arbitrary offset to a valid port index.
    function automatic port_idx_t wrap_port(input int value, input int num_ports);
        return port_idx_t'(value % num_ports);
    endfunction

endpackage

// File: rtl/swq_fifo.sv
// swq_fifo: synchronous show-ahead FIFO with a DEPTH+1-state occupancy count,
// so all DEPTH slots are usable. A push on a full FIFO is accepted only when
// the same edge also pops.
module swq_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Occupancy next state: net change of +1, -1 or 0.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and count update; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/switch_ingress_queues.sv
// switch_ingress_queues: bus writes are pushed into per-port FIFOs and a
// round-robin arbiter drains them into one registered valid/ready egress.
// Optional per-port saturating drop counters are built when the macro
// SWQ_DROP_CNT_EN is defined; otherwise drops are silent and addr 4..7 read 0.
module switch_ingress_queues
    import swq_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_port
);

    logic [MAX_PORTS-1:0] push_w, pop_w, full_w, empty_w;
    logic [DATA_W-1:0]    head_w [MAX_PORTS];

    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_data_q;
    port_idx_t            out_port_q;
    port_idx_t            last_grant_q;
    logic [7:0]           readdata_q;

    logic                 load_w;
    logic                 grant_valid;
    port_idx_t            grant_idx;
    logic [DATA_W-1:0]    grant_data;
    port_idx_t            cand;
    logic [7:0]           rd_value;

    assign load_w = !out_valid_q || out_ready;

    // One queue per implemented port; unimplemented slots look permanently empty.
    for (genvar gi = 0; gi < MAX_PORTS; gi++) begin : g_q
        if (gi < NUM_PORTS) begin : g_impl
            assign push_w[gi] = chipselect && write && (address == ADDR_Q_BASE + 3'(gi));
            assign pop_w[gi]  = load_w && grant_valid && (grant_idx == port_idx_t'(gi));

            swq_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push_w[gi]),
                .pop   (pop_w[gi]),
                .din   (writedata[DATA_W-1:0]),
                .dout  (head_w[gi]),
                .empty (empty_w[gi]),
                .full  (full_w[gi])
            );
        end else begin : g_absent
            assign push_w[gi]  = 1'b0;
            assign pop_w[gi]   = 1'b0;
            assign empty_w[gi] = 1'b1;
            assign full_w[gi]  = 1'b0;
            assign head_w[gi]  = '0;
        end
    end

    // Round-robin search from last_grant+1; scanning offsets high-to-low lets
    // the nearest non-empty queue overwrite farther candidates.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant_q;
        grant_data  = '0;
        cand        = '0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            cand = wrap_port(int'(last_grant_q) + off, NUM_PORTS);
            if (!empty_w[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant_data  = head_w[cand];
            end
        end
    end

    // Egress register: reload when free or being consumed, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_port_q   <= '0;
            last_grant_q <= port_idx_t'(NUM_PORTS - 1);
        end else if (load_w) begin
            if (grant_valid) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= grant_data;
                out_port_q   <= grant_idx;
                last_grant_q <= grant_idx;
            end else begin
                out_valid_q  <= 1'b0;
            end
        end
    end

`ifdef SWQ_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q [NUM_PORTS];

    // Per-port drop counters: saturate at 255, cleared by reading them; a drop
    // coinciding with the clearing read leaves the counter at 1.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_drop
        logic                  clear_w;
        logic                  drop_w;
        logic [DROP_CNT_W-1:0] drop_cnt_d;

        assign clear_w = chipselect && read && (address == ADDR_DROP_BASE + 3'(gi));
        assign drop_w  = push_w[gi] && full_w[gi] && !pop_w[gi];

        // Counter next state.
        always_comb begin
            drop_cnt_d = drop_cnt_q[gi];
            if (clear_w) begin
                drop_cnt_d = {{(DROP_CNT_W-1){1'b0}}, drop_w};
            end else if (drop_w && (drop_cnt_q[gi] != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_d = drop_cnt_q[gi] + 1'b1;
            end
        end

        // Counter register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                drop_cnt_q[gi] <= '0;
            end else begin
                drop_cnt_q[gi] <= drop_cnt_d;
            end
        end
    end
`endif

    // Read mux: status word, drop counters, zero elsewhere.
    always_comb begin
        rd_value = '0;
        if (address == ADDR_STATUS) begin
            rd_value = {1'b0, full_w, 1'b0, empty_w};
        end
`ifdef SWQ_DROP_CNT_EN
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (address == ADDR_DROP_BASE + 3'(k)) begin
                rd_value = drop_cnt_q[k];
            end
        end
`endif
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (chipselect && read) begin
            readdata_q <= rd_value;
        end
    end

    assign readdata  = readdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

endmodule

// File: tb/tb_switch_ingress_queues.sv
// Self-checking bench for switch_ingress_queues: a directed vector table,
// hand-written corner sequences and a randomized run against a queue-based
// reference model. Follows SWQ_DROP_CNT_EN the same way as the design.
module tb_switch_ingress_queues;

    localparam int NP    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       chipselect, write, read, out_ready;
    logic [2:0] address;
    logic [7:0] writedata, readdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_port;

    always #5 clk = ~clk;

    switch_ingress_queues #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_port   (out_port)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mq [NP][$];
    int m_lg, m_ev, m_data, m_port, m_rdata;
    int m_drop [NP];

    // Entries the DUT actually handed off (sampled before each edge)
    int got_data [$];
    int got_port [$];

    typedef struct {
        bit cs, wr, rd;
        int addr, wd;
        bit rdy;
        bit ev;
        int ed, ep, erd;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            mq[k].delete();
            m_drop[k] = 0;
        end
        m_lg = NP - 1; m_ev = 0; m_data = 0; m_port = 0; m_rdata = 0;
    endtask

    // One clock edge of the behavioural model, from pre-edge state.
    task automatic model_step(input bit cs, wr, rd, input int addr, wd, input bit rdy);
        int g;
        if (cs && rd) begin
            if (addr == 0) begin
                m_rdata = 0;
                for (int k = 0; k < 3; k++) begin
                    if (k < NP && mq[k].size() == DEPTH) m_rdata |= (1 << (4 + k));
                    if (k >= NP || mq[k].size() == 0)    m_rdata |= (1 << k);
                end
            end else if (addr >= 4 && addr - 4 < NP) begin
`ifdef SWQ_DROP_CNT_EN
                m_rdata = m_drop[addr-4];
                m_drop[addr-4] = 0;
`else
                m_rdata = 0;
`endif
            end else begin
                m_rdata = 0;
            end
        end
        if (m_ev == 0 || rdy) begin
            g = -1;
            for (int off = 1; off <= NP; off++) begin
                int c;
                c = (m_lg + off) % NP;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                m_data = mq[g].pop_front();
                m_port = g; m_lg = g; m_ev = 1;
            end else begin
                m_ev = 0;
            end
        end
        if (cs && wr && addr >= 1 && addr <= NP) begin
            if (mq[addr-1].size() < DEPTH) begin
                mq[addr-1].push_back(wd & 8'hFF);
            end else begin
`ifdef SWQ_DROP_CNT_EN
                if (m_drop[addr-1] < 255) m_drop[addr-1]++;
`endif
            end
        end
    endtask

    task automatic tick(input bit cs, wr, rd, input int addr, wd, input bit rdy);
        chipselect = cs; write = wr; read = rd;
        address = addr[2:0]; writedata = wd[7:0]; out_ready = rdy;
        if (out_valid && out_ready) begin
            got_data.push_back(int'(out_data));
            got_port.push_back(int'(out_port));
        end
        @(posedge clk);
        model_step(cs, wr, rd, addr, wd, rdy);
        #1;
        chk("out_valid", int'(out_valid), m_ev);
        chk("out_data", int'(out_data), m_data);
        chk("out_port", int'(out_port), m_port);
        chk("readdata", int'(readdata), m_rdata);
        $display("t=%0t cs=%0b wr=%0b rd=%0b a=%0d wd=%02h rdy=%0b | v=%0b d=%02h p=%0d rd=%02h",
                 $time, cs, wr, rd, addr, wd & 8'hFF, rdy, out_valid, out_data, out_port, readdata);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        int exp_d [5];
        int exp_p [5];
        int n_q1, held_d, held_p;
        bit saw_ff;

        reset = 1'b1; chipselect = 0; write = 0; read = 0;
        address = 0; writedata = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_readdata", int'(readdata), 0);

        // Directed vector table
        tbl[0] = '{1,0,1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h07};
        tbl[1] = '{1,1,0, 1, 8'hA1, 1, 0, 8'h00, 0, 8'h07};
        tbl[2] = '{0,0,0, 0, 8'h00, 1, 1, 8'hA1, 0, 8'h07};
        tbl[3] = '{0,0,0, 0, 8'h00, 1, 0, 8'hA1, 0, 8'h07};
        tbl[4] = '{1,1,0, 3, 8'h5C, 0, 0, 8'hA1, 0, 8'h07};
        tbl[5] = '{1,0,1, 0, 8'h00, 0, 1, 8'h5C, 2, 8'h03};
        tbl[6] = '{0,0,0, 0, 8'h00, 1, 0, 8'h5C, 2, 8'h03};
        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].cs, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
            chk("tbl_valid", int'(out_valid), int'(tbl[i].ev));
            chk("tbl_data", int'(out_data), tbl[i].ed);
            chk("tbl_port", int'(out_port), tbl[i].ep);
            chk("tbl_readdata", int'(readdata), tbl[i].erd);
        end

        // Round-robin fairness with preloaded queues
        got_data.delete(); got_port.delete();
        tick(1,1,0, 1, 8'h10, 0);
        tick(1,1,0, 1, 8'h11, 0);
        tick(1,1,0, 2, 8'h20, 0);
        tick(1,1,0, 3, 8'h30, 0);
        tick(1,1,0, 3, 8'h31, 0);
        idle(1, 8);
        exp_d = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h31};
        exp_p = '{0, 1, 2, 0, 2};
        chk("rr_count", got_data.size(), 5);
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            chk("rr_data", got_data[i], exp_d[i]);
            chk("rr_port", got_port[i], exp_p[i]);
        end

        // Overflow: egress occupied, queue1 filled, fifth push dropped
        got_data.delete(); got_port.delete();
        tick(1,1,0, 1, 8'h55, 0);
        idle(0, 1);
        for (int i = 0; i < 4; i++) tick(1,1,0, 2, 8'h60 + i, 0);
        tick(1,1,0, 2, 8'hFF, 0);
        tick(1,0,1, 0, 0, 0);
        chk("full_status", int'(readdata), 8'h25);
        idle(1, 8);
        n_q1 = 0; saw_ff = 0;
        foreach (got_data[i]) begin
            if (got_port[i] == 1) n_q1++;
            if (got_data[i] == 8'hFF) saw_ff = 1;
        end
        chk("ovf_q1_entries", n_q1, 4);
        chk("ovf_ff_absent", int'(saw_ff), 0);
        tick(1,0,1, 5, 0, 1);
`ifdef SWQ_DROP_CNT_EN
        chk("drop_cnt_first", int'(readdata), 1);
`else
        chk("drop_cnt_first", int'(readdata), 0);
`endif
        tick(1,0,1, 5, 0, 1);
        chk("drop_cnt_reread", int'(readdata), 0);

        // Backpressure hold for 5 cycles
        tick(1,1,0, 1, 8'h71, 0);
        tick(1,1,0, 3, 8'h72, 0);
        idle(0, 1);
        held_d = int'(out_data); held_p = int'(out_port);
        chk("hold_loaded", held_d, 8'h71);
        for (int i = 0; i < 5; i++) begin
            tick(1,0,(i % 2 == 0), 0, 0, 0);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), held_d);
            chk("hold_port", int'(out_port), held_p);
            chk("hold_status", int'(readdata), 8'h03);
        end

        // Asynchronous reset mid-operation
        tick(1,1,0, 2, 8'h81, 0);
        tick(1,1,0, 2, 8'h82, 0);
        #3 reset = 1'b1;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_data", int'(out_data), 0);
        chk("async_port", int'(out_port), 0);
        chk("async_readdata", int'(readdata), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick(1,0,1, 0, 0, 1);
        chk("post_reset_status", int'(readdata), 8'h07);
        tick(0,0,0, 0, 0, 1);
        chk("post_reset_valid", int'(out_valid), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 1),
                 $urandom_range(0, 9) < 3, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), $urandom_range(0, 9) < 6);
        end
        idle(1, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
